// File: rtl/fifo_read_ctrl.sv
// Pops a 1-cycle-latency FIFO into a 2-entry skid buffer feeding a valid/ready stream.
// Optional rd_count delivered-word counter enabled with `define FIFO_READ_CNT_EN.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_READ_CNT_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  // State encoding doubles as the stored-word count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]            r_state;
  logic                  r_inflight;
  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;

  logic       w_pop;
  logic       w_cap;
  logic [1:0] w_credit;

  assign w_pop    = m_valid && m_ready;
  assign w_cap    = r_inflight;
  assign w_credit = r_state + {1'b0, r_inflight} - {1'b0, w_pop};

  // r_run holds off pops until the first clock edge after reset release.
  assign rd_en   = r_run && !empty && (w_credit < 2'd2);
  assign m_valid = (r_state != ST_EMPTY);
  assign m_data  = r_buf0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= rd_en;
      case (r_state)
        ST_EMPTY: begin
          if (w_cap) begin
            r_buf0  <= data_out;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_cap && w_pop) begin
            r_buf0 <= data_out;
          end else if (w_cap) begin
            r_buf1  <= data_out;
            r_state <= ST_TWO;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_buf0 <= r_buf1;
            if (w_cap) begin
              r_buf1 <= data_out;
            end else begin
              r_state <= ST_ONE;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`ifdef FIFO_READ_CNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'h0000;
    end else if (w_pop) begin
      r_count <= r_count + 16'h0001;
    end
  end

  assign rd_count = r_count;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: behavioural 1-cycle-latency FIFO plus an expected-word queue.
module tb_fifo_read_ctrl;
  localparam int DW = 8;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          empty    = 1'b1;
  logic          rd_en;
  logic [DW-1:0] data_out = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready  = 1'b0;
`ifdef FIFO_READ_CNT_EN
  logic [15:0]   rd_count;
`endif

  int n_cmp    = 0;
  int n_err    = 0;
  int viol_cnt = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_read_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .empty    (empty),
    .rd_en    (rd_en),
    .data_out (data_out),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready)
`ifdef FIFO_READ_CNT_EN
    ,
    .rd_count (rd_count)
`endif
  );

  // FIFO model: read data appears one cycle after rd_en, empty is registered.
  always @(posedge clk) begin
    if (rd_en) begin
      if (empty || fifo_q.size() == 0) viol_cnt <= viol_cnt + 1;
      else data_out <= fifo_q.pop_front();
    end
    empty <= (fifo_q.size() == 0);
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    push_word(8'hAA);
    push_word(8'hBB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (rd_en !== 1'b0) begin
        n_err++;
        $display("FAIL reset_rd_en cycle %0d got %b exp 0", i, rd_en);
      end
    end
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_m_valid got %b exp 0", m_valid);
    end
    n_cmp++;
    if (m_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_m_data got %h exp 00", m_data);
    end
`ifdef FIFO_READ_CNT_EN
    n_cmp++;
    if (rd_count !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_rd_count got %h exp 0000", rd_count);
    end
`endif
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL release_rd_en got %b exp 0 before first edge", rd_en);
    end
  endtask

  task automatic test_stream3();
    logic          rh[16];
    logic          vh[16];
    int            c0;
    logic [DW-1:0] w;
    do_reset();
    m_ready = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      rh[i] = rd_en;
      vh[i] = m_valid;
      if (m_valid && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream3_extra got %h exp none", m_data);
        end else begin
          w = exp_q.pop_front();
          if (m_data !== w) begin
            n_err++;
            $display("FAIL stream3_data got %h exp %h", m_data, w);
          end
        end
      end
    end
    c0 = -1;
    for (int i = 15; i >= 0; i--) if (rh[i]) c0 = i;
    n_cmp++;
    if (c0 < 0 || c0 > 8) begin
      n_err++;
      $display("FAIL stream3_first_rd_en got cycle %0d exp 0..8", c0);
    end else begin
      n_cmp++;
      if ({rh[c0], rh[c0+1], rh[c0+2], rh[c0+3]} !== 4'b1110) begin
        n_err++;
        $display("FAIL stream3_rd_en_run got %b exp 1110",
                 {rh[c0], rh[c0+1], rh[c0+2], rh[c0+3]});
      end
      n_cmp++;
      if ({vh[c0], vh[c0+1], vh[c0+2], vh[c0+3], vh[c0+4], vh[c0+5]} !== 6'b001110) begin
        n_err++;
        $display("FAIL stream3_valid_timing got %b exp 001110",
                 {vh[c0], vh[c0+1], vh[c0+2], vh[c0+3], vh[c0+4], vh[c0+5]});
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream3_left got %0d words exp 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int            pulses;
    int            unstable;
    int            got;
    int            first_i;
    int            last_i;
    logic [DW-1:0] w;
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'(8'h51 + i));
    pulses   = 0;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (rd_en) pulses++;
      if (m_valid && m_data !== 8'h51) unstable++;
    end
    n_cmp++;
    if (pulses != 2) begin
      n_err++;
      $display("FAIL bp_rd_en_pulses got %0d exp 2", pulses);
    end
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h51 || unstable != 0) begin
      n_err++;
      $display("FAIL bp_hold got valid %b data %h unstable %0d exp 1 51 0", m_valid, m_data, unstable);
    end
    got     = 0;
    first_i = -1;
    last_i  = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid) begin
        n_cmp++;
        if (first_i < 0) first_i = i;
        last_i = i;
        got++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra got %h exp none", m_data);
        end else begin
          w = exp_q.pop_front();
          if (m_data !== w) begin
            n_err++;
            $display("FAIL bp_data got %h exp %h", m_data, w);
          end
        end
      end
    end
    n_cmp++;
    if (got != 5 || last_i - first_i != 4) begin
      n_err++;
      $display("FAIL bp_no_gaps got %0d words over %0d cycles exp 5 over 5", got, last_i - first_i + 1);
    end
  endtask

  task automatic test_empty();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      m_ready = i[0];
      #1;
      if (rd_en || m_valid) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL empty_idle got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int            got;
    int            stale;
    logic [DW-1:0] w;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(8'h80 + i));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (m_valid) begin
        n_cmp++;
        w = exp_q.pop_front();
        if (m_data !== w) begin
          n_err++;
          $display("FAIL mid_pre_data got %h exp %h", m_data, w);
        end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (!(m_valid && rd_en)) begin
      n_err++;
      $display("FAIL mid_busy got valid %b rd_en %b exp 1 1", m_valid, rd_en);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async_clear got valid %b data %h rd_en %b exp 0 00 0", m_valid, m_data, rd_en);
    end
`ifdef FIFO_READ_CNT_EN
    n_cmp++;
    if (rd_count !== 16'h0000) begin
      n_err++;
      $display("FAIL mid_rd_count got %h exp 0000", rd_count);
    end
`endif
    fifo_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (m_valid) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_err++;
      $display("FAIL mid_stale got %0d valid cycles exp 0", stale);
    end
    push_word(8'hC1);
    push_word(8'hC2);
    push_word(8'hC3);
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (m_valid) begin
        n_cmp++;
        got++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL mid_post_extra got %h exp none", m_data);
        end else begin
          w = exp_q.pop_front();
          if (m_data !== w) begin
            n_err++;
            $display("FAIL mid_post_data got %h exp %h", m_data, w);
          end
        end
      end
    end
    n_cmp++;
    if (got != 3) begin
      n_err++;
      $display("FAIL mid_post_count got %0d exp 3", got);
    end
  endtask

  task automatic test_random();
    int            to_send;
    int            cyc;
    logic [DW-1:0] w;
    do_reset();
    to_send = 1000;
    cyc     = 0;
    while ((to_send > 0 || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      m_ready = 1'($urandom_range(0, 1));
      if (to_send > 0 && $urandom_range(0, 3) != 0) begin
        push_word(8'($urandom_range(0, 255)));
        to_send--;
      end
      #1;
      if (m_valid && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra got %h exp none", m_data);
        end else begin
          w = exp_q.pop_front();
          if (m_data !== w) begin
            n_err++;
            $display("FAIL rand_data got %h exp %h", m_data, w);
          end
        end
      end
    end
    n_cmp++;
    if (to_send != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_timeout got %0d words pending exp 0", to_send + exp_q.size());
    end
    n_cmp++;
    if (viol_cnt != 0) begin
      n_err++;
      $display("FAIL rd_en_while_empty got %0d exp 0", viol_cnt);
    end
  endtask

`ifdef FIFO_READ_CNT_EN
  task automatic test_count_wrap();
    int            cyc;
    logic [DW-1:0] w;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 65537; i++) push_word(8'(i));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 70000) begin
      @(negedge clk);
      cyc++;
      #1;
      if (m_valid) begin
        w = exp_q.pop_front();
        if (m_data !== w) begin
          n_cmp++;
          n_err++;
          $display("FAIL wrap_data got %h exp %h", m_data, w);
        end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || rd_count !== 16'h0001) begin
      n_err++;
      $display("FAIL wrap_rd_count got %h (%0d pending) exp 0001", rd_count, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream3();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_random();
`ifdef FIFO_READ_CNT_EN
    test_count_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
